// File: rtl/axil_axis_fifo_pkg.sv
// axil_axis_fifo_pkg: register word addresses and identification constants of the CPU-to-stream FIFO.
package axil_axis_fifo_pkg;
  localparam logic [31:0] PCORE_VERSION = 32'h0001_0069;
  localparam logic [31:0] MAGIC_FIFO = 32'h4649_464F;
  localparam logic [31:0] MAGIC_69 = 32'h6969_6969;
  localparam logic [31:0] REG_VERSION = 32'd0;
  localparam logic [31:0] REG_ID = 32'd1;
  localparam logic [31:0] REG_ZERO = 32'd2;
  localparam logic [31:0] REG_MAGIC = 32'd3;
  localparam logic [31:0] REG_MAGIC2 = 32'd4;
  localparam logic [31:0] REG_LEVEL = 32'd5;
  localparam logic [31:0] REG_STATUS = 32'd6;
  localparam logic [31:0] REG_PUSH = 32'd7;
  localparam logic [31:0] REG_USER = 32'd8;
  localparam logic [31:0] REG_PUSH_LAST = 32'd9;
  localparam logic [31:0] REG_OVF = 32'd10;
  localparam logic [31:0] REG_CTRL = 32'd11;
endpackage

// File: rtl/axil_axis_fifo_axi_lite.sv
// axil_axis_fifo_axi_lite: AXI-lite slave to single-cycle req/ack register port; one transaction per channel in flight.
module axil_axis_fifo_axi_lite #(
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [ADDRESS_WIDTH-1:0] s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [ADDRESS_WIDTH-1:0] s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic                     rreq,
  output logic [ADDRESS_WIDTH-3:0] raddr,
  input  logic [31:0]              rdata,
  input  logic                     rack,
  output logic                     wreq,
  output logic [ADDRESS_WIDTH-3:0] waddr,
  output logic [31:0]              wdata,
  input  logic                     wack
);
  logic wbusy, rbusy, unused;
  assign unused = ^{s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;
  // ready pulses coincide with req, so the register port sees each access exactly once
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      {s_axi_awready, s_axi_wready, s_axi_bvalid, wreq, wbusy} <= '0;
      {s_axi_arready, s_axi_rvalid, rreq, rbusy} <= '0;
      {waddr, wdata, raddr, s_axi_rdata} <= '0;
    end else begin
      {s_axi_awready, s_axi_wready, wreq} <= '0;
      {s_axi_arready, rreq} <= '0;
      if (!wbusy && s_axi_awvalid && s_axi_wvalid) begin
        {s_axi_awready, s_axi_wready, wreq, wbusy} <= '1;
        waddr <= s_axi_awaddr[ADDRESS_WIDTH-1:2];
        wdata <= s_axi_wdata;
      end
      if (wack) s_axi_bvalid <= 1'b1;
      else if (s_axi_bvalid && s_axi_bready) {s_axi_bvalid, wbusy} <= '0;
      if (!rbusy && s_axi_arvalid) begin
        {s_axi_arready, rreq, rbusy} <= '1;
        raddr <= s_axi_araddr[ADDRESS_WIDTH-1:2];
      end
      if (rack) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata <= rdata;
      end else if (s_axi_rvalid && s_axi_rready) {s_axi_rvalid, rbusy} <= '0;
    end
  end
endmodule

// File: rtl/axil_axis_fifo.sv
// axil_axis_fifo: CPU-to-stream FIFO; AXI-lite pushes words, registered AXI-stream output stage drains them.
module axil_axis_fifo
  import axil_axis_fifo_pkg::*;
#(
  parameter int ID = 0,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_LEN = 8,
  parameter int USER_WIDTH = 1,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     clear_i,
  output logic [DATA_WIDTH-1:0]    m_axis_out_tdata,
  output logic [USER_WIDTH-1:0]    m_axis_out_tuser,
  output logic                     m_axis_out_tlast,
  output logic                     m_axis_out_tvalid,
  input  logic                     m_axis_out_tready,
  input  logic [ADDRESS_WIDTH-1:0] s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [ADDRESS_WIDTH-1:0] s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready
);
  localparam int PW = $clog2(FIFO_LEN) + 1;
  localparam int MW = USER_WIDTH + 1 + DATA_WIDTH;
  localparam int AW = ADDRESS_WIDTH - 2;
  logic rreq, wreq, rack, wack, full, empty, flush, push_req, push, load, mem_empty, unused_w;
  logic [AW-1:0] raddr, waddr;
  logic [31:0] rdata, wdata, rmux, ra, wa, ovf;
  logic [MW-1:0] mem [FIFO_LEN];
  logic [PW-1:0] wr_ptr, rd_ptr, level;
  logic [USER_WIDTH-1:0] user_q;
  axil_axis_fifo_axi_lite #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_axil (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .rreq(rreq), .raddr(raddr), .rdata(rdata), .rack(rack),
    .wreq(wreq), .waddr(waddr), .wdata(wdata), .wack(wack)
  );
  assign unused_w = ^wdata;
  assign ra = 32'(raddr);
  assign wa = 32'(waddr);
  // level includes the word parked in the output register
  assign level = wr_ptr - rd_ptr + PW'(m_axis_out_tvalid);
  assign full = level == PW'(FIFO_LEN);
  assign empty = level == '0;
  assign mem_empty = wr_ptr == rd_ptr;
  assign flush = clear_i || (wreq && wa == REG_CTRL && wdata[0]);
  assign push_req = wreq && (wa == REG_PUSH || wa == REG_PUSH_LAST) && !flush;
  assign push = push_req && !full;
  assign load = (!m_axis_out_tvalid || m_axis_out_tready) && !mem_empty;
  always_comb begin
    rmux = '0;
    case (ra)
      REG_VERSION: rmux = PCORE_VERSION;
      REG_ID:      rmux = 32'(ID);
      REG_ZERO:    rmux = '0;
      REG_MAGIC:   rmux = MAGIC_FIFO;
      REG_MAGIC2:  rmux = MAGIC_69;
      REG_LEVEL:   rmux = 32'(level);
      REG_STATUS:  rmux = {30'b0, empty, full};
      REG_USER:    rmux = 32'(user_q);
      REG_OVF:     rmux = ovf;
      default:     rmux = '0;
    endcase
  end
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr[PW-2:0]] <= {user_q, wa == REG_PUSH_LAST, wdata[DATA_WIDTH-1:0]};
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      {wr_ptr, rd_ptr, user_q, ovf, rack, wack, rdata} <= '0;
      {m_axis_out_tvalid, m_axis_out_tdata, m_axis_out_tuser, m_axis_out_tlast} <= '0;
    end else begin
      rack <= rreq;
      wack <= wreq;
      if (rreq) rdata <= rmux;
      if (wreq && wa == REG_USER) user_q <= wdata[USER_WIDTH-1:0];
      if (wreq && wa == REG_OVF) ovf <= '0;
      else if (push_req && full && ovf != '1) ovf <= ovf + 32'd1;
      if (flush) begin
        {wr_ptr, rd_ptr} <= '0;
        {m_axis_out_tvalid, m_axis_out_tdata, m_axis_out_tuser, m_axis_out_tlast} <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (load) begin
          {m_axis_out_tuser, m_axis_out_tlast, m_axis_out_tdata} <= mem[rd_ptr[PW-2:0]];
          m_axis_out_tvalid <= 1'b1;
          rd_ptr <= rd_ptr + PW'(1);
        end else if (m_axis_out_tready) m_axis_out_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axil_axis_fifo.sv
// tb_axil_axis_fifo: directed + random bench; expected stream kept as a queue of accepted pushes.
module tb_axil_axis_fifo;
  logic clk_i = 0, reset_ni = 0, clear_i = 0;
  logic [15:0] m_tdata;
  logic m_tuser, m_tlast, m_tvalid, m_tready = 0;
  logic [15:0] awaddr = 0, araddr = 0;
  logic awvalid = 0, awready, wvalid = 0, wready, bvalid, arvalid = 0, arready, rvalid;
  logic [31:0] wdata = 0, rdata;
  logic [1:0] bresp, rresp;
  logic [17:0] beat, hold_b = 0;
  logic [17:0] sent[$], got[$];
  logic rnd_ready = 0, ready_fix = 0, mon_en = 1, hold_v = 0, user_m = 0, l;
  logic [15:0] d;
  logic [31:0] rd;
  int cyc = 0, wcyc = 0, first_cyc = -1, hold_err = 0, cmp_idx = 0, ovf_m = 0, n_chk = 0, n_fail = 0, t;

  axil_axis_fifo #(.ID(42), .DATA_WIDTH(16), .FIFO_LEN(8), .USER_WIDTH(1), .ADDRESS_WIDTH(16)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .clear_i(clear_i),
    .m_axis_out_tdata(m_tdata), .m_axis_out_tuser(m_tuser), .m_axis_out_tlast(m_tlast),
    .m_axis_out_tvalid(m_tvalid), .m_axis_out_tready(m_tready),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(4'hF), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(1'b1),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(1'b1)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  assign beat = {m_tuser, m_tlast, m_tdata};

  initial forever begin
    @(posedge clk_i); #1;
    m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  // records accepted beats and any change of a stalled beat
  always @(negedge clk_i) begin
    if (reset_ni && m_tvalid && first_cyc < 0) first_cyc = cyc;
    if (reset_ni && m_tvalid && m_tready) got.push_back(beat);
    if (mon_en && hold_v && !(m_tvalid && beat == hold_b)) hold_err++;
    hold_v = mon_en && reset_ni && m_tvalid && !m_tready;
    hold_b = beat;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input int a, input logic [31:0] v);
    int k;
    @(posedge clk_i); #1;
    awaddr = 16'(a * 4); wdata = v; awvalid = 1; wvalid = 1;
    k = 0;
    @(negedge clk_i);
    while (!awready && k < 20) begin @(negedge clk_i); k++; end
    check("aw_handshake", 32'({awready, wready}), 32'h3);
    wcyc = cyc;
    @(posedge clk_i); #1;
    awvalid = 0; wvalid = 0;
    k = 0;
    @(negedge clk_i);
    while (!bvalid && k < 20) begin @(negedge clk_i); k++; end
    check("b_response", 32'({bvalid, bresp}), 32'h4);
  endtask

  task automatic axi_read(input int a, output logic [31:0] v);
    int k;
    @(posedge clk_i); #1;
    araddr = 16'(a * 4); arvalid = 1;
    k = 0;
    @(negedge clk_i);
    while (!arready && k < 20) begin @(negedge clk_i); k++; end
    @(posedge clk_i); #1;
    arvalid = 0;
    k = 0;
    @(negedge clk_i);
    while (!rvalid && k < 20) begin @(negedge clk_i); k++; end
    check("r_response", 32'({rvalid, rresp}), 32'h4);
    v = rdata;
  endtask

  task automatic read_check(input string tag, input int a, input logic [31:0] exp);
    logic [31:0] v;
    axi_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic push(input logic last, input logic [15:0] dv);
    if (sent.size() - got.size() < 8) sent.push_back({user_m, last, dv});
    else ovf_m++;
    axi_write(last ? 9 : 7, {16'($urandom), dv});
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (got.size() < sent.size() && k < 2000) begin @(negedge clk_i); k++; end
    repeat (4) @(negedge clk_i);
    check({tag, "_count"}, 32'(got.size()), 32'(sent.size()));
    while (cmp_idx < sent.size()) begin
      if (cmp_idx < got.size()) check(tag, 32'(got[cmp_idx]), 32'(sent[cmp_idx]));
      cmp_idx++;
    end
  endtask

  task automatic discard_pending();
    while (sent.size() > got.size()) void'(sent.pop_back());
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 reset_ni = 1;
    // 1: identification and reset state
    read_check("version", 0, 32'h0001_0069);
    read_check("id", 1, 42);
    read_check("reg2", 2, 0);
    read_check("magic", 3, 32'h4649_464F);
    read_check("magic2", 4, 32'h6969_6969);
    read_check("level_rst", 5, 0);
    read_check("status_rst", 6, 32'h2);
    read_check("ovf_rst", 10, 0);
    read_check("unmapped", 20, 0);
    // 2: user tagging, tlast selection, latency
    ready_fix = 1;
    user_m = 1;
    axi_write(8, 1);
    read_check("user_rb", 8, 1);
    push(0, 16'h1234);
    t = wcyc;
    push(1, 16'h5678);
    drain("beat_basic");
    check("latency", 32'(first_cyc - t), 2);
    // 3: overflow while stalled
    ready_fix = 0;
    for (int i = 0; i < 10; i++) push(0, 16'($urandom));
    read_check("status_full", 6, 32'h1);
    read_check("level_full", 5, 8);
    read_check("ovf_two", 10, 32'(ovf_m));
    ready_fix = 1;
    drain("beat_full");
    read_check("status_drained", 6, 32'h2);
    // 4: random backpressure with pointer wrap
    rnd_ready = 1;
    for (int i = 0; i < 100; i++) begin
      if (i % 16 == 5) begin
        user_m = 1'($urandom);
        axi_write(8, 32'(user_m));
      end
      t = 0;
      while (sent.size() - got.size() >= 8 && t < 200) begin @(negedge clk_i); t++; end
      d = 16'($urandom);
      l = 1'($urandom);
      push(l, d);
    end
    rnd_ready = 0;
    ready_fix = 1;
    drain("beat_rand");
    read_check("ovf_rand", 10, 32'(ovf_m));
    // 5: flush via clear_i and via control register
    ready_fix = 0;
    for (int i = 0; i < 4; i++) push(0, 16'($urandom));
    read_check("level_half", 5, 4);
    mon_en = 0;
    @(posedge clk_i); #1 clear_i = 1;
    @(negedge clk_i);
    check("tvalid_pre_clear", 32'(m_tvalid), 1);
    @(posedge clk_i); #1 clear_i = 0;
    @(negedge clk_i);
    check("tvalid_clear", 32'(m_tvalid), 0);
    discard_pending();
    read_check("level_clear", 5, 0);
    read_check("ovf_clear", 10, 32'(ovf_m));
    read_check("user_clear", 8, 32'(user_m));
    for (int i = 0; i < 3; i++) push(1, 16'($urandom));
    axi_write(11, 0);
    read_check("level_ctrl0", 5, 3);
    axi_write(11, 1);
    check("tvalid_ctrl", 32'(m_tvalid), 0);
    discard_pending();
    read_check("level_ctrl", 5, 0);
    read_check("ovf_ctrl", 10, 32'(ovf_m));
    mon_en = 1;
    ready_fix = 1;
    push(0, 16'hBEEF);
    push(1, 16'hCAFE);
    drain("beat_after_flush");
    axi_write(10, 32'h1234);
    ovf_m = 0;
    read_check("ovf_wclear", 10, 0);
    // 6: reset mid-stream with a write in flight
    ready_fix = 0;
    for (int i = 0; i < 3; i++) push(0, 16'($urandom));
    mon_en = 0;
    @(posedge clk_i); #1;
    awaddr = 16'(7 * 4); wdata = 32'hAAAA; awvalid = 1; wvalid = 1;
    @(posedge clk_i); #1 reset_ni = 0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("rst_tvalid", 32'(m_tvalid), 0);
    check("rst_beat", 32'(beat), 0);
    check("rst_aw_w_b", 32'({awready, wready, bvalid}), 0);
    check("rst_ar_r", 32'({arready, rvalid}), 0);
    check("rst_rdata", rdata, 0);
    @(posedge clk_i); #1;
    awvalid = 0; wvalid = 0; reset_ni = 1;
    discard_pending();
    user_m = 0;
    ovf_m = 0;
    mon_en = 1;
    read_check("level_post_rst", 5, 0);
    read_check("user_post_rst", 8, 0);
    read_check("ovf_post_rst", 10, 0);
    ready_fix = 1;
    push(1, 16'h0F0F);
    drain("beat_post_rst");
    check("hold_stable", 32'(hold_err), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
